// File: rtl/sumador_pkg.sv
// Shared types for the pipelined adder/subtractor: operation encoding and
// the status-flag bundle carried alongside each result.
package sumador_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

endpackage

// File: rtl/sumador_n.sv
// Combinational N-bit ripple-carry adder; one instance per pipeline stage
// so each stage only carries half of the full chain.
module sumador_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/sumador_restador_pipe.sv
// Two-stage pipelined adder/subtractor with valid/ready on both sides; the
// carry chain is split between stages, low half first.
module sumador_restador_pipe
  import sumador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LO_W  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_num,
  input  logic [WIDTH-1:0] b_num,
  input  logic             carry_in,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int HI_W = WIDTH - LO_W;

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [LO_W-1:0]  lo_sum;
  logic             c_mid;
  logic             xfer;
  logic             adv2;

  logic             s1_valid_q, s1_valid_d;
  logic [LO_W-1:0]  lo_q;
  logic             c_mid_q;
  logic [HI_W-1:0]  a_hi_q;
  logic [HI_W-1:0]  b_hi_q;

  logic [HI_W-1:0]  hi_sum;
  logic             c_out;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  // Overflow only needs the operand sign bits, which travel in the high halves.
  function automatic flags_t calc_flags(input logic [WIDTH-1:0] res,
                                        input logic a_msb,
                                        input logic b_msb,
                                        input logic cy);
    flags_t f;
    f.carry    = cy;
    f.overflow = (a_msb == b_msb) && (res[WIDTH-1] != a_msb);
    f.zero     = ~|res;
    f.negative = res[WIDTH-1];
    return f;
  endfunction

  always_comb begin
    b_eff = b_num;
    cin   = 1'b0;
    case (op_e'(op))
      OP_ADD: begin b_eff = b_num;  cin = 1'b0;     end
      OP_SUB: begin b_eff = ~b_num; cin = 1'b1;     end
      OP_ADC: begin b_eff = b_num;  cin = carry_in; end
      OP_SBB: begin b_eff = ~b_num; cin = carry_in; end
      default: ;
    endcase
  end

  assign adv2     = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || adv2;
  assign xfer     = in_valid && in_ready;

  // ---- stage 1: low half of the carry chain ----
  sumador_n #(.N(LO_W)) u_lo (
    .a    (a_num[LO_W-1:0]),
    .b    (b_eff[LO_W-1:0]),
    .cin  (cin),
    .sum  (lo_sum),
    .cout (c_mid)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (xfer)      s1_valid_d = 1'b1;
    else if (adv2) s1_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      lo_q    <= lo_sum;
      c_mid_q <= c_mid;
      a_hi_q  <= a_num[WIDTH-1:LO_W];
      b_hi_q  <= b_eff[WIDTH-1:LO_W];
    end
  end

  // ---- stage 2: high half, flags and output register ----
  sumador_n #(.N(HI_W)) u_hi (
    .a    (a_hi_q),
    .b    (b_hi_q),
    .cin  (c_mid_q),
    .sum  (hi_sum),
    .cout (c_out)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (adv2) begin
      out_valid_d = 1'b1;
      result_d    = {hi_sum, lo_q};
      flags_d     = calc_flags({hi_sum, lo_q}, a_hi_q[HI_W-1], b_hi_q[HI_W-1], c_out);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;

endmodule

// File: tb/tb_sumador_restador_pipe.sv
// Scoreboard bench for sumador_restador_pipe: driver pushes expected beats
// from an arithmetic reference model, an independent monitor pops on output.
module tb_sumador_restador_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_num = '0;
  logic [W-1:0] b_num = '0;
  logic         carry_in = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry_out, overflow, zero, negative;

  int checks = 0;
  int errors = 0;
  bit rnd_mode = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic c, v, z, n;
  } exp_t;

  exp_t exp_q[$];

  sumador_restador_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_num     (a_num),
    .b_num     (b_num),
    .carry_in  (carry_in),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input int a, input int b, input int opv, input int ci);
    exp_t e;
    int beff, c, s, sa, sb, ss;
    case (opv)
      0:       begin beff = b;              c = 0;  end
      1:       begin beff = (~b) & 255;     c = 1;  end
      2:       begin beff = b;              c = ci; end
      default: begin beff = (~b) & 255;     c = ci; end
    endcase
    s  = a + beff + c;
    sa = (a >= 128) ? a - 256 : a;
    sb = (beff >= 128) ? beff - 256 : beff;
    ss = sa + sb + c;
    e.res = W'(s % 256);
    e.c   = (s >= 256);
    e.v   = (ss > 127) || (ss < -128);
    e.z   = ((s % 256) == 0);
    e.n   = ((s % 256) >= 128);
    return e;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Called just after a posedge; returns just after the transfer posedge.
  task automatic send(input int a, input int b, input int opv, input int ci);
    bit acc;
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    a_num    = W'(a);
    b_num    = W'(b);
    op       = 2'(opv);
    carry_in = ci[0];
    while (!done) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(model(a, b, opv, ci));
        done = 1'b1;
      end
      #1;
      n++;
      if (!done && n > 200) begin
        check("send_timeout", 1, 0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    a_num    = W'($urandom);
    b_num    = W'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever is presented; pops only when accepted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q[0];
          check("result", int'(result), int'(e.res));
          check("flags", int'({carry_out, overflow, zero, negative}),
                int'({e.c, e.v, e.z, e.n}));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int n;
    #2;
    check("reset_outputs", int'({out_valid, result, carry_out, overflow, zero, negative}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_reset", int'(in_ready), 1);

    // Latency: offered right after an edge, visible after the second edge.
    in_valid = 1'b1; a_num = 8'h05; b_num = 8'h06; op = 2'd0; carry_in = 1'b0;
    @(posedge clk);
    exp_q.push_back(model(5, 6, 0, 0));
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_not_early", int'(out_valid), 0);
    @(negedge clk);
    check("latency_2", int'(out_valid), 1);
    tick();

    // Directed vectors: {a, b, op, carry_in}
    send(8'hFF, 8'hFF, 0, 0);
    send(8'h7F, 8'h01, 0, 0);
    send(8'h07, 8'h05, 1, 0);
    send(8'h05, 8'h07, 1, 0);
    send(8'h33, 8'h33, 1, 1);
    send(8'h10, 8'h01, 3, 0);
    send(8'hFE, 8'h01, 2, 1);
    send(8'h80, 8'h01, 1, 0);
    repeat (4) tick();
    check("directed_drained", exp_q.size(), 0);

    // Backpressure: two beats fill the pipe, the third must stall.
    out_ready = 1'b0;
    send(1, 1, 0, 0);
    send(2, 2, 0, 0);
    in_valid = 1'b1; a_num = 8'h03; b_num = 8'h03; op = 2'd0; carry_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_in_ready", int'(in_ready), 0);
      check("full_hold_result", int'(result), 8'h02);
      tick();
    end
    out_ready = 1'b1;
    send(3, 3, 0, 0);
    send(4, 4, 0, 0);
    repeat (4) tick();
    check("backpressure_drained", exp_q.size(), 0);

    // Randomized traffic with random consumer stalls and input gaps.
    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send($urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 3), $urandom_range(0, 1));
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    check("random_drained", exp_q.size(), 0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(8'h11, 8'h22, 0, 0);
    send(8'h33, 8'h44, 0, 0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_outputs",
          int'({out_valid, result, carry_out, overflow, zero, negative}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_spurious_valid", int'(out_valid), 0);
    end
    tick();
    send(8'h05, 8'h06, 0, 0);
    repeat (4) tick();
    check("post_reset_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
